// File: rtl/flow_stats_table.sv
// Per-flow statistics table: hashes each flow key into a direct-mapped table of
// saturating packet/byte counters, counts dropped colliding keys, and offers a read port and bulk clear.
module flow_stats_table #(
  parameter int KEY_W   = 104,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_W-1:0]   key,
  input  logic [15:0]        pkt_len,
  input  logic               rd_req,
  output logic               rd_ready,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic               rd_hit,
  output logic [KEY_W-1:0]   rd_key,
  output logic [CNT_W-1:0]   rd_pkts,
  output logic [CNT_W-1:0]   rd_bytes,
  input  logic               clear_req,
  output logic               busy,
  output logic [15:0]        coll_cnt
);

  localparam int DEPTH  = 1 << INDEX_W;
  localparam int NCHUNK = (KEY_W + INDEX_W - 1) / INDEX_W;
  localparam int PAD_W  = NCHUNK * INDEX_W;
  localparam int SUM_W  = ((CNT_W > 16) ? CNT_W : 16) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_UPDATE = 3'd3,
    ST_RDOUT  = 3'd4
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] pkts;
    logic [CNT_W-1:0] bytes;
  } entry_t;

  function automatic logic [INDEX_W-1:0] hash_idx(input logic [KEY_W-1:0] k);
    logic [PAD_W-1:0]   p;
    logic [INDEX_W-1:0] h;
    p = PAD_W'(k);
    h = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      h = h ^ p[c*INDEX_W +: INDEX_W];
    end
    return h;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [15:0] l);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(l);
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    if (a == CNT_MAX) begin
      return a;
    end else begin
      return a + CNT_W'(1);
    end
  endfunction

  state_t             state_r;
  logic [INDEX_W-1:0] clr_ptr_r;
  logic               clr_pend_r;
  logic [KEY_W-1:0]   key_r;
  logic [15:0]        len_r;
  logic [INDEX_W-1:0] idx_r;
  logic               busy_r;
  logic               key_ready_r;
  logic               rd_ready_r;
  logic               rd_valid_r;
  logic               rd_hit_r;
  logic [KEY_W-1:0]   rd_key_r;
  logic [CNT_W-1:0]   rd_pkts_r;
  logic [CNT_W-1:0]   rd_bytes_r;
  logic [15:0]        coll_cnt_r;

  entry_t             mem_r [DEPTH];
  entry_t             rdata_r;

  logic [INDEX_W-1:0] rd_addr_s;
  logic               key_match_s;
  entry_t             upd_entry_s;
  logic               we_s;
  logic [INDEX_W-1:0] waddr_s;
  entry_t             wdata_s;

  // Table port control: read address, updated entry and write selection
  always_comb begin
    rd_addr_s         = (state_r == ST_LOOKUP) ? idx_r : rd_idx;
    key_match_s       = rdata_r.vld && (rdata_r.key == key_r);
    upd_entry_s.vld   = 1'b1;
    upd_entry_s.key   = key_r;
    upd_entry_s.pkts  = rdata_r.vld ? sat_inc(rdata_r.pkts) : CNT_W'(1);
    upd_entry_s.bytes = sat_add(rdata_r.vld ? rdata_r.bytes : '0, len_r);
    we_s              = 1'b0;
    waddr_s           = idx_r;
    wdata_s           = upd_entry_s;
    case (state_r)
      ST_CLEAR: begin
        we_s    = busy_r;
        waddr_s = clr_ptr_r;
        wdata_s = '0;
      end
      ST_UPDATE: begin
        we_s    = !rdata_r.vld || key_match_s;
        waddr_s = idx_r;
        wdata_s = upd_entry_s;
      end
      default: begin
        we_s    = 1'b0;
        waddr_s = idx_r;
        wdata_s = upd_entry_s;
      end
    endcase
  end

  // Table storage; contents are initialised by the clear walk rather than by reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Registered table read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else begin
      rdata_r <= mem_r[rd_addr_s];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      clr_ptr_r   <= '0;
      clr_pend_r  <= 1'b0;
      key_r       <= '0;
      len_r       <= 16'd0;
      idx_r       <= '0;
      busy_r      <= 1'b0;
      key_ready_r <= 1'b0;
      rd_ready_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_hit_r    <= 1'b0;
      rd_key_r    <= '0;
      rd_pkts_r   <= '0;
      rd_bytes_r  <= '0;
      coll_cnt_r  <= 16'd0;
    end else begin
      rd_valid_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          // First cycle out of reset only arms the walk
          if (!busy_r) begin
            busy_r <= 1'b1;
          end else begin
            clr_ptr_r <= clr_ptr_r + INDEX_W'(1);
            if (clr_ptr_r == {INDEX_W{1'b1}}) begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              key_ready_r <= 1'b1;
              rd_ready_r  <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (rd_req) begin
            state_r     <= ST_RDOUT;
            key_ready_r <= 1'b0;
            rd_ready_r  <= 1'b0;
            clr_pend_r  <= clear_req;
          end else if (key_valid) begin
            state_r     <= ST_LOOKUP;
            key_r       <= key;
            len_r       <= pkt_len;
            idx_r       <= hash_idx(key);
            key_ready_r <= 1'b0;
            rd_ready_r  <= 1'b0;
            clr_pend_r  <= clear_req;
          end else if (clear_req) begin
            state_r     <= ST_CLEAR;
            clr_ptr_r   <= '0;
            busy_r      <= 1'b1;
            clr_pend_r  <= 1'b0;
            coll_cnt_r  <= 16'd0;
            key_ready_r <= 1'b0;
            rd_ready_r  <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          state_r <= ST_UPDATE;
          if (clear_req) begin
            clr_pend_r <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (rdata_r.vld && !key_match_s && (coll_cnt_r != 16'hFFFF)) begin
            coll_cnt_r <= coll_cnt_r + 16'd1;
          end
          if (clr_pend_r || clear_req) begin
            state_r    <= ST_CLEAR;
            clr_ptr_r  <= '0;
            busy_r     <= 1'b1;
            clr_pend_r <= 1'b0;
            coll_cnt_r <= 16'd0;
          end else begin
            state_r     <= ST_IDLE;
            key_ready_r <= 1'b1;
            rd_ready_r  <= 1'b1;
          end
        end
        ST_RDOUT: begin
          rd_valid_r <= 1'b1;
          rd_hit_r   <= rdata_r.vld;
          rd_key_r   <= rdata_r.vld ? rdata_r.key   : '0;
          rd_pkts_r  <= rdata_r.vld ? rdata_r.pkts  : '0;
          rd_bytes_r <= rdata_r.vld ? rdata_r.bytes : '0;
          if (clr_pend_r || clear_req) begin
            state_r    <= ST_CLEAR;
            clr_ptr_r  <= '0;
            busy_r     <= 1'b1;
            clr_pend_r <= 1'b0;
            coll_cnt_r <= 16'd0;
          end else begin
            state_r     <= ST_IDLE;
            key_ready_r <= 1'b1;
            rd_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          clr_ptr_r   <= '0;
          busy_r      <= 1'b0;
          key_ready_r <= 1'b0;
          rd_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = key_ready_r;
  assign rd_ready  = rd_ready_r;
  assign rd_valid  = rd_valid_r;
  assign rd_hit    = rd_hit_r;
  assign rd_key    = rd_key_r;
  assign rd_pkts   = rd_pkts_r;
  assign rd_bytes  = rd_bytes_r;
  assign busy      = busy_r;
  assign coll_cnt  = coll_cnt_r;

endmodule
